// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, controller and datapath
// in one block. Signed and unsigned operands are handled by extending both to
// WIDTH+1 bits and running WIDTH+1 fused add/shift iterations.
//
// Handshake: start is sampled only in IDLE. busy is high in INIT, RUN and
// DONE. valid is a one-cycle pulse in DONE, and hi/lo carry the product
// during that pulse and hold it until the next DONE or RST.
//
// Optional feature macro: MULT_OVF_FLAG_EN adds a registered overflow output
// that flags a product that does not fit in WIDTH bits.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands captured on the start edge
    logic [WIDTH-1:0] m_in;
    logic [WIDTH-1:0] q_in;
    logic             sgn_in;

    // Booth working registers: {acc_a, acc_q, q_m1} is the shifting word
    logic [W1-1:0]    acc_a;
    logic [W1-1:0]    acc_q;
    logic             q_m1;
    logic [W1-1:0]    m_ext;
    logic [CW-1:0]    count;

    // One Booth iteration and the product it would yield if it is the last
    logic [W1-1:0]    sum;
    logic [W1-1:0]    a_shift;
    logic [W1-1:0]    q_shift;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    // Extend an operand to W1 bits according to the captured signedness
    function automatic logic [W1-1:0] ext(input logic sgn, input logic [WIDTH-1:0] x);
        return {sgn & x[WIDTH-1], x};
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                valid     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Fused Booth add/subtract and arithmetic right shift of {A,Q,q_1}
    always_comb begin
        sum = acc_a;
        case ({acc_q[0], q_m1})
            2'b01:   sum = acc_a + m_ext;
            2'b10:   sum = acc_a - m_ext;
            default: sum = acc_a;
        endcase
        a_shift = {sum[W1-1], sum[W1-1:1]};
        q_shift = {sum[0], acc_q[W1-1:1]};
        // Low 2*WIDTH bits of the shifted {A,Q}
        prod_hi = {a_shift[WIDTH-2:0], q_shift[WIDTH]};
        prod_lo = q_shift[WIDTH-1:0];
    end

`ifdef MULT_OVF_FLAG_EN
    logic ovf_nxt;

    // Product does not fit in WIDTH bits of the selected signedness
    always_comb begin
        if (sgn_in) begin
            ovf_nxt = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
        end else begin
            ovf_nxt = (prod_hi != '0);
        end
    end
`endif

    // Datapath: capture, initialise, iterate and register the result
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_in     <= '0;
            q_in     <= '0;
            sgn_in   <= 1'b0;
            acc_a    <= '0;
            acc_q    <= '0;
            q_m1     <= 1'b0;
            m_ext    <= '0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULT_OVF_FLAG_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_in   <= multiplicand;
                        q_in   <= multiplier;
                        sgn_in <= is_signed;
                    end
                end
                S_INIT: begin
                    acc_a <= '0;
                    acc_q <= ext(sgn_in, q_in);
                    q_m1  <= 1'b0;
                    m_ext <= ext(sgn_in, m_in);
                    count <= CW'(W1);
                end
                S_RUN: begin
                    acc_a <= a_shift;
                    acc_q <= q_shift;
                    q_m1  <= acc_q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        hi       <= prod_hi;
                        lo       <= prod_lo;
`ifdef MULT_OVF_FLAG_EN
                        overflow <= ovf_nxt;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq (WIDTH=32): directed table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
// Overflow checks are compiled in when MULT_OVF_FLAG_EN is defined.
module tb_booth_mult_seq;

    localparam int W       = 32;
    localparam int LAT     = W + 3;
    localparam int TIMEOUT = 200;

    logic         CLK;
    logic         RST;
    logic         start;
    logic         is_signed;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULT_OVF_FLAG_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard: {ovf, hi, lo} expected at each valid pulse, in order
    logic [2*W:0] exp_q[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .valid        (valid),
        .hi           (hi),
        .lo           (lo)
`ifdef MULT_OVF_FLAG_EN
        ,
        .overflow     (overflow)
`endif
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [2*W:0] got, input logic [2*W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // DUT result word; overflow bit is 0 when the feature is not built
    function automatic logic [2*W:0] dut_word();
`ifdef MULT_OVF_FLAG_EN
        return {overflow, hi, lo};
`else
        return {1'b0, hi, lo};
`endif
    endfunction

    function automatic logic [2*W:0] mask_exp(input logic [2*W:0] e);
`ifdef MULT_OVF_FLAG_EN
        return e;
`else
        return {1'b0, e[2*W-1:0]};
`endif
    endfunction

    // Reference model: plain 64-bit arithmetic on the operands' values
    function automatic logic [2*W:0] model(input logic sgn, input logic [W-1:0] m, input logic [W-1:0] q);
        longint          sp;
        longint unsigned up;
        longint          lim;
        logic            ovf;
        lim = 64'sd2147483648;
        if (sgn) begin
            sp  = longint'($signed(m)) * longint'($signed(q));
            ovf = (sp < -lim) || (sp >= lim);
            return {ovf, sp[2*W-1:0]};
        end
        up  = {32'b0, m} * {32'b0, q};
        ovf = (up >= 64'h1_0000_0000);
        return {ovf, up[2*W-1:0]};
    endfunction

    // Scoreboard consumer: every valid pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (!RST && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {1'b1, hi, lo}, '0);
            end else begin
                check("scoreboard_result", dut_word(), mask_exp(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    // Drive start for one edge; afterwards the bench sits in cycle k+1
    task automatic start_op(input logic sgn, input logic [W-1:0] m, input logic [W-1:0] q);
        is_signed    = sgn;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start        = 1'b0;
        is_signed    = 1'($urandom_range(0, 1));
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Wait for valid; n0 is the cycle index (relative to the start edge) now
    task automatic wait_done(input int n0, output int lat);
        int n;
        int busy_low;
        n        = n0;
        busy_low = 0;
        lat      = -1;
        while (n <= TIMEOUT) begin
            if (busy !== 1'b1) busy_low++;
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
            step();
            n++;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no valid within %0d cycles", TIMEOUT);
        end
        check("busy_during_op", (2*W+1)'(busy_low), '0);
    endtask

    // One full multiply with latency, pulse width and hold checks
    task automatic run_check(input string name, input logic sgn, input logic [W-1:0] m,
                             input logic [W-1:0] q, input logic [2*W:0] e);
        int lat;
        exp_q.push_back(e);
        start_op(sgn, m, q);
        wait_done(1, lat);
        check({name, "_latency"}, (2*W+1)'(lat), (2*W+1)'(LAT));
        step();
        check({name, "_after_pulse"}, {{(2*W-1){1'b0}}, valid, busy}, '0);
        check({name, "_hold"}, dut_word(), mask_exp(e));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string        name;
        logic         sgn;
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
        logic         e_ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int           lat;
        logic [W-1:0] rm;
        logic [W-1:0] rq;
        logic         rs;

        tbl[0] = '{"u_ones_x_ones",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
        tbl[1] = '{"s_7_x_m3",       1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{"s_min_x_min",    1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
        tbl[3] = '{"s_m1_x_m1",      1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[4] = '{"u_2p16_sq",      1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1};
        tbl[5] = '{"s_m2_x_3",       1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        tbl[6] = '{"s_zero_x_m1",    1'b1, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        tbl[7] = '{"u_2p31_x_2",     1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b1};
        tbl[8] = '{"s_max_x_min",    1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b1};
        tbl[9] = '{"u_ones_x_zero",  1'b0, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000, 1'b0};

        // Reset
        RST          = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) step();
        RST = 1'b0;
        check("reset_state", {{(2*W-1){1'b0}}, valid, busy}, '0);
        check("reset_result", dut_word(), '0);
        step();

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            run_check(tbl[i].name, tbl[i].sgn, tbl[i].m, tbl[i].q,
                      {tbl[i].e_ovf, tbl[i].e_hi, tbl[i].e_lo});
        end

        // start while busy: second request at edge k+10 must be ignored
        exp_q.push_back({1'b0, 32'd0, 32'd30});
        start_op(1'b0, 32'd5, 32'd6);
        repeat (8) step();
        is_signed    = 1'b0;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        step();
        start        = 1'b0;
        wait_done(10, lat);
        check("busy_start_latency", (2*W+1)'(lat), (2*W+1)'(LAT));
        repeat (40) step();
        check("busy_start_hold", dut_word(), mask_exp({1'b0, 32'd0, 32'd30}));

        // Reset mid-run: aborts without a valid pulse and clears the result
        start_op(1'b0, 32'd1234, 32'd5678);
        repeat (10) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("midrun_rst_state", {{(2*W-1){1'b0}}, valid, busy}, '0);
        check("midrun_rst_result", dut_word(), '0);
        repeat (40) step();
        run_check("rst_then_3x4", 1'b0, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12});

        // Back-to-back with hold between pulses
        run_check("b2b_2x3", 1'b0, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6});
        run_check("b2b_0xones", 1'b0, 32'd0, 32'hFFFFFFFF, {1'b0, 32'd0, 32'd0});

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            rm = $urandom;
            rq = $urandom;
            if ($urandom_range(0, 3) == 0) rm = (i % 2 == 0) ? 32'h80000000 : 32'h7FFFFFFF;
            if ($urandom_range(0, 3) == 0) rq = (i % 3 == 0) ? 32'hFFFFFFFF : 32'd1;
            run_check("random", rs, rm, rq, model(rs, rm, rq));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
        end

        repeat (5) step();
        check("scoreboard_drained", (2*W+1)'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier for the multi-cycle datapath. Controller and datapath are in one block.
- Supports signed and unsigned operands and produces a 2*WIDTH product on HI/LO outputs.
- Uses a start/busy/valid handshake toward the multi-cycle control FSM.
- Add and shift are fused into one cycle per iteration.

Parameters:
- WIDTH, 32, operand width in bits. Legal range is 2 or more. The counter width is a derived localparam, clog2(WIDTH+2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- multiplicand  input  WIDTH  operand M; captured on the start edge
- multiplier  input  WIDTH  operand Q; captured on the start edge
- busy  output  1  high in INIT, RUN and DONE
- valid  output  1  one-cycle pulse; hi/lo are valid during it
- hi  output  WIDTH  upper half of the product
- lo  output  WIDTH  lower half of the product
- overflow  output  1  only present with MULT_OVF_FLAG_EN

Behaviour:
- Reset:
  - RST is sampled on the CLK edge and has priority over everything.
  - After reset: state=IDLE; busy=0, valid=0, hi=0, lo=0, overflow=0; all internal registers cleared.
  - A reset mid-operation aborts the multiply. No valid pulse is produced.
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - If start=1 at an edge, capture multiplicand, multiplier and is_signed, then go to INIT.
  - Otherwise stay in IDLE.
- INIT (1 cycle):
  - Extend each operand to W1=WIDTH+1 bits: sign-extend when is_signed=1, zero-extend when 0.
  - Load A=0 (W1 bits), Q=ext(multiplier), q_1=0, M=ext(multiplicand), count=W1.
  - Go to RUN.
- RUN (exactly W1 cycles):
  - Each cycle, select on {Q[0],q_1}: 01 gives A+M; 10 gives A-M; 00 and 11 give A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by one, replicating the MSB of A.
  - Decrement count. When count==1 at the edge, go to DONE.
  - All arithmetic is W1-bit modulo.
- DONE (1 cycle):
  - valid=1, and hi/lo = low 2*WIDTH bits of {A,Q}.
  - hi/lo are registered on entry to DONE.
  - Go to IDLE.
- Latency:
  - start sampled at edge k: INIT during cycle k+1, RUN during cycles k+2..k+WIDTH+2, valid high during cycle k+WIDTH+3.
  - Total is WIDTH+3 cycles, independent of operand values.
- Back-to-back: a start may be asserted in the cycle after DONE; the next valid follows WIDTH+3 cycles later.
- start while busy=1: ignored. Operands are not re-captured and the in-flight result is unaffected.
- hi/lo hold the last result until the next DONE or RST. valid is never high outside DONE.
- Operand changes after the start edge have no effect.
- Boundary cases, all via the W1 extension:
  - signed most-negative times most-negative is correct;
  - unsigned all-ones operands are correct;
  - multiply by 0 gives 0.

Optional Feature:
- Macro: MULT_OVF_FLAG_EN.
- Defined:
  - The overflow port exists and is registered together with hi/lo on entry to DONE.
  - Signed: overflow=1 when hi != {WIDTH{lo[WIDTH-1]}}.
  - Unsigned: overflow=1 when hi != 0.
  - Reset value is 0; the value holds like hi/lo.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Unsigned latency: WIDTH=32, is_signed=0, 0xFFFFFFFF*0xFFFFFFFF, start at edge k -> valid only in cycle k+35; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles k+1..k+35.
- Signed corners:
  - 7*-3 (0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000;
  - -1*-1 -> hi=0, lo=1.
- Start while busy: 5*6 started; at edge k+10 drive start=1 with 9*9 -> single valid at k+35 with lo=30, hi=0; no second valid.
- Reset mid-run: start 1234*5678, assert RST for one edge at k+12 -> next cycle busy=0, valid=0, hi=lo=0, no valid pulse; then start 3*4 -> lo=12 after 35 cycles.
- Back-to-back and hold: start 2*3, then start 0*0xFFFFFFFF in the cycle after valid -> lo=6 followed by lo=0 (hi=0); hi/lo hold between pulses.
- Overflow (MULT_OVF_FLAG_EN defined):
  - unsigned 0x10000*0x10000 -> hi=1, lo=0, overflow=1;
  - signed -2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, overflow=0;
  - build without the macro -> port absent, results unchanged.
